alu_mem_sequencer: RTL and testbench
====================================

ALU_MEM_SEQUENCER -- requirements
Module: alu_mem_sequencer

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set memory address width (512 words); data width SHALL be fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  requester has a command.
REQ-005 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-006 cmd_op  input  4  ALU ctrl code: 0 add, 1 sub, 2 rsb, 3 mul4bithigh, 4 nor, 5 not, 6 nand, 7 xnor, 8 srl, 9 sll, 10 ror, 11 rol, 12-15 nop.
REQ-007 cmd_addr_a, cmd_addr_b, cmd_addr_z  input  ADDR_W each  operand A, operand B, and result addresses.
REQ-008 mem_Enable, mem_WE, mem_RE  output  1 each  memory controls.
REQ-009 mem_address  output  ADDR_W; mem_data_in  output  8; mem_data_out  input  8 (registered read data, valid the cycle after an RE cycle).
REQ-010 alu_ain, alu_bin  output  8; alu_ctrl  output  4; alu_zout  input  8; alu_overflow  input  1 (combinational ALU).
REQ-011 done  output  1  one-cycle completion pulse; result  output  8; result_ovf  output  1.

Function
REQ-012 Handshake: command SHALL be accepted on an edge where cmd_valid && cmd_ready; all cmd_* fields SHALL be latched at that edge.
REQ-013 cmd_ready SHALL equal (state==IDLE) && !rst; cmd_valid while busy SHALL be ignored and the requester SHALL hold it.
REQ-014 FSM states and transitions: IDLE -> RDA (on accept) -> RDB -> WAITB -> EXEC -> WR -> IDLE; no other transitions except via rst or REQ-024.
REQ-015 RDA: mem_Enable=1, mem_RE=1, mem_WE=0, mem_address=addr_a.
REQ-016 RDB: same controls, mem_address=addr_b; opa SHALL capture mem_data_out at the end of RDB.
REQ-017 WAITB: memory controls idle; opb SHALL capture mem_data_out at the end of WAITB.
REQ-018 EXEC: alu_ain=opa, alu_bin=opb, alu_ctrl=op; result and result_ovf SHALL capture alu_zout and alu_overflow at the end of EXEC.
REQ-019 WR: mem_Enable=1, mem_WE=1, mem_RE=0, mem_address=addr_z, mem_data_in=result.
REQ-020 Outside RDA/RDB/WR, mem_Enable, mem_WE and mem_RE SHALL be 0; mem_WE and mem_RE SHALL never both be 1.
REQ-021 done SHALL be high for exactly the first IDLE cycle after WR; latency SHALL be 6 cycles from the accept edge to done high; result/result_ovf SHALL hold until the next capture.
REQ-022 A new command SHALL be acceptable in the done cycle (throughput of 1 command per 6 cycles).
REQ-023 Aliased addresses (a==b, z==a, z==b) SHALL work, because both reads complete before the write.

Reset
REQ-024 While rst=1 at an edge: state SHALL go to IDLE, done=0, result=8'h00, result_ovf=0, opa=opb=0, and all memory controls SHALL be 0 from the next cycle; a command in progress SHALL be abandoned with no write.

Configuration
REQ-025 Macro ALU_SEQ_NOP_SKIP_EN: when defined, a command with cmd_op 12-15 SHALL go IDLE -> IDLE without memory access, leave result unchanged, and pulse done in the cycle after accept (latency 1); when undefined, nop codes SHALL run the full 6-cycle sequence and write alu_zout.

Verification
REQ-026 mem[3]=8'h25, mem[4]=8'h13, op=0, a=3, b=4, z=5 -> done 6 cycles after accept, result=8'h38, mem[5]=8'h38.
REQ-027 mem[7]=8'h0F, op=1, a=7, b=7, z=7 (full alias) -> mem[7]=8'h00, result=8'h00.
REQ-028 Two back-to-back commands with cmd_valid held high -> second accepted in the first done cycle, second done exactly 6 cycles later, cmd_ready low in between.
REQ-029 rst asserted in the cycle the FSM is in EXEC -> no mem_WE pulse, done never asserted, result=8'h00, cmd_ready=1 the cycle after rst drops.
REQ-030 op=12 with mem[9]=8'hAA, z=9: with ALU_SEQ_NOP_SKIP_EN -> done 1 cycle after accept, mem_Enable stays 0, mem[9]=8'hAA; without -> done after 6 cycles and mem[9]=ALU nop output.
REQ-031 Protocol checker on every run: never mem_WE && mem_RE, no mem_Enable while IDLE, and exactly one done per accepted command.

Source files
------------

// File: rtl/alu_mem_sequencer.sv
// alu_mem_sequencer: fetches two operands from a single-port memory, runs them
// through an external combinational ALU and writes the result back.
// Sequence: IDLE -> RDA -> RDB -> WAITB -> EXEC -> WR -> IDLE, done in the IDLE
// cycle that follows WR.
// Optional build macro ALU_SEQ_NOP_SKIP_EN: nop codes (12-15) bypass memory and
// ALU entirely and pulse done one cycle after accept with result unchanged.
module alu_mem_sequencer #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [ADDR_W-1:0] cmd_addr_z,
    output logic              mem_Enable,
    output logic              mem_WE,
    output logic              mem_RE,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_data_in,
    input  logic [7:0]        mem_data_out,
    output logic [7:0]        alu_ain,
    output logic [7:0]        alu_bin,
    output logic [3:0]        alu_ctrl,
    input  logic [7:0]        alu_zout,
    input  logic              alu_overflow,
    output logic              done,
    output logic [7:0]        result,
    output logic              result_ovf
);

    typedef enum logic [2:0] {
        IDLE,
        RDA,
        RDB,
        WAITB,
        EXEC,
        WR
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [3:0]        op;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_z;
    logic [7:0]        opa;
    logic [7:0]        opb;
    logic              accept;
    logic              skip;

    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

`ifdef ALU_SEQ_NOP_SKIP_EN
    assign skip = (cmd_op[3:2] == 2'b11);
`else
    assign skip = 1'b0;
`endif

    // ALU operands come straight from the captured registers; only EXEC samples them.
    assign alu_ain     = opa;
    assign alu_bin     = opb;
    assign alu_ctrl    = op;
    assign mem_data_in = result;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing and memory control decode.
    always_comb begin
        state_next  = state;
        mem_Enable  = 1'b0;
        mem_WE      = 1'b0;
        mem_RE      = 1'b0;
        mem_address = '0;
        case (state)
            IDLE: begin
                if (accept && !skip) begin
                    state_next = RDA;
                end
            end
            RDA: begin
                mem_Enable  = 1'b1;
                mem_RE      = 1'b1;
                mem_address = addr_a;
                state_next  = RDB;
            end
            RDB: begin
                mem_Enable  = 1'b1;
                mem_RE      = 1'b1;
                mem_address = addr_b;
                state_next  = WAITB;
            end
            WAITB: begin
                state_next = EXEC;
            end
            EXEC: begin
                state_next = WR;
            end
            WR: begin
                mem_Enable  = 1'b1;
                mem_WE      = 1'b1;
                mem_address = addr_z;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command latch, operand/result capture and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            op         <= '0;
            addr_a     <= '0;
            addr_b     <= '0;
            addr_z     <= '0;
            opa        <= '0;
            opb        <= '0;
            result     <= '0;
            result_ovf <= 1'b0;
            done       <= 1'b0;
        end else begin
            // WR always returns to IDLE, so flagging WR marks the first IDLE cycle.
            done <= (state == WR) || (accept && skip);
            if (accept) begin
                op     <= cmd_op;
                addr_a <= cmd_addr_a;
                addr_b <= cmd_addr_b;
                addr_z <= cmd_addr_z;
            end
            if (state == RDB) begin
                opa <= mem_data_out;
            end
            if (state == WAITB) begin
                opb <= mem_data_out;
            end
            if (state == EXEC) begin
                result     <= alu_zout;
                result_ovf <= alu_overflow;
            end
        end
    end

endmodule

// File: tb/tb_alu_mem_sequencer.sv
// Scoreboard bench for alu_mem_sequencer: a behavioural memory and ALU sit
// around the DUT; stimulus pushes hand-computed expectations, a negedge
// monitor pops them on every done pulse and also watches the bus protocol.
module tb_alu_mem_sequencer;

    typedef struct {
        int         id;
        logic [7:0] res;
        logic       ovf;
        logic [8:0] z;
        logic [7:0] mem_val;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [8:0] cmd_addr_a;
    logic [8:0] cmd_addr_b;
    logic [8:0] cmd_addr_z;
    logic       mem_Enable;
    logic       mem_WE;
    logic       mem_RE;
    logic [8:0] mem_address;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
    logic [7:0] alu_ain;
    logic [7:0] alu_bin;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_zout;
    logic       alu_overflow;
    logic       done;
    logic [7:0] result;
    logic       result_ovf;

    logic [7:0] mem [0:511];
    logic       pre_we;
    logic [8:0] pre_addr;
    logic [7:0] pre_data;

    int   checks;
    int   failures;
    int   proto_err;
    int   cyc;
    exp_t exp_q[$];
    int   acc_q[$];

    alu_mem_sequencer #(.ADDR_W(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr_a   (cmd_addr_a),
        .cmd_addr_b   (cmd_addr_b),
        .cmd_addr_z   (cmd_addr_z),
        .mem_Enable   (mem_Enable),
        .mem_WE       (mem_WE),
        .mem_RE       (mem_RE),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .alu_ain      (alu_ain),
        .alu_bin      (alu_bin),
        .alu_ctrl     (alu_ctrl),
        .alu_zout     (alu_zout),
        .alu_overflow (alu_overflow),
        .done         (done),
        .result       (result),
        .result_ovf   (result_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory with registered read data; pre_we is a bench backdoor.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_Enable && mem_WE) begin
            mem[mem_address] <= mem_data_in;
        end
        if (mem_Enable && mem_RE) begin
            mem_data_out <= mem[mem_address];
        end
    end

    // Combinational ALU stand-in; codes 12-15 produce 8'h00.
    logic [8:0]  alu_wide;
    logic [15:0] alu_mul;
    always_comb begin
        alu_wide     = '0;
        alu_mul      = alu_ain * alu_bin;
        alu_zout     = 8'h00;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            4'd0: begin alu_wide = {1'b0, alu_ain} + {1'b0, alu_bin}; alu_zout = alu_wide[7:0]; alu_overflow = alu_wide[8]; end
            4'd1: begin alu_wide = {1'b0, alu_ain} - {1'b0, alu_bin}; alu_zout = alu_wide[7:0]; alu_overflow = alu_wide[8]; end
            4'd2: begin alu_wide = {1'b0, alu_bin} - {1'b0, alu_ain}; alu_zout = alu_wide[7:0]; alu_overflow = alu_wide[8]; end
            4'd3:  alu_zout = alu_mul[15:8];
            4'd4:  alu_zout = ~(alu_ain | alu_bin);
            4'd5:  alu_zout = ~alu_ain;
            4'd6:  alu_zout = ~(alu_ain & alu_bin);
            4'd7:  alu_zout = ~(alu_ain ^ alu_bin);
            4'd8:  alu_zout = alu_ain >> 1;
            4'd9:  alu_zout = alu_ain << 1;
            4'd10: alu_zout = {alu_ain[0], alu_ain[7:1]};
            4'd11: alu_zout = {alu_ain[6:0], alu_ain[7]};
            default: alu_zout = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: protocol watch, accept timestamps, scoreboard pop on done.
    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
        end else begin
            if (mem_WE && mem_RE) proto_err++;
            if (cmd_ready && mem_Enable) proto_err++;
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
            if (done) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    int   t;
                    e = exp_q.pop_front();
                    t = acc_q.pop_front();
                    check($sformatf("cmd%0d_result", e.id), {24'd0, result}, {24'd0, e.res});
                    check($sformatf("cmd%0d_ovf", e.id), {31'd0, result_ovf}, {31'd0, e.ovf});
                    check($sformatf("cmd%0d_mem", e.id), {24'd0, mem[e.z]}, {24'd0, e.mem_val});
                    check($sformatf("cmd%0d_latency", e.id), cyc - t, e.lat);
                end
            end
        end
    end

    task automatic preload(input logic [8:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // Presents a command and returns just after the accepting edge with cmd_valid still high.
    task automatic send(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b,
                        input logic [8:0] z, input bit push, input exp_t e);
        int n;
        cmd_op     = op;
        cmd_addr_a = a;
        cmd_addr_b = b;
        cmd_addr_z = z;
        cmd_valid  = 1'b1;
        if (push) exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 50);
        if (!cmd_ready) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int id, input logic [7:0] res, input logic ovf,
                                input logic [8:0] z, input logic [7:0] mv, input int lat);
        exp_t e;
        e.id = id; e.res = res; e.ovf = ovf; e.z = z; e.mem_val = mv; e.lat = lat;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   low_cnt;
        logic we_seen;
        logic done_seen;
        exp_t dummy;

        checks     = 0;
        failures   = 0;
        proto_err  = 0;
        cyc        = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_addr_a = '0;
        cmd_addr_b = '0;
        cmd_addr_z = '0;
        pre_we     = 1'b0;
        pre_addr   = '0;
        pre_data   = '0;
        dummy      = mk(0, 8'h00, 1'b0, 9'd0, 8'h00, 0);

        preload(9'd3,  8'h25);
        preload(9'd4,  8'h13);
        preload(9'd5,  8'h00);
        preload(9'd7,  8'h0F);
        preload(9'd9,  8'hAA);
        preload(9'd10, 8'hF0);
        preload(9'd11, 8'h20);
        preload(9'd12, 8'h00);
        preload(9'd13, 8'h77);
        preload(9'd20, 8'hF0);
        preload(9'd21, 8'h3C);
        preload(9'd22, 8'h00);
        preload(9'd30, 8'h5A);
        preload(9'd31, 8'hC3);

        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_mem_enable", {31'd0, mem_Enable}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_rst_done", {31'd0, done}, 32'd0);
        check("post_rst_result", {24'd0, result}, 32'd0);
        check("post_rst_ovf", {31'd0, result_ovf}, 32'd0);
        @(posedge clk);
        #1;

        // 25 + 13
        send(4'd0, 9'd3, 9'd4, 9'd5, 1'b1, mk(1, 8'h38, 1'b0, 9'd5, 8'h38, 6));
        cmd_valid = 1'b0;
        drain();

        // full alias: 0F - 0F into the same word
        send(4'd1, 9'd7, 9'd7, 9'd7, 1'b1, mk(2, 8'h00, 1'b0, 9'd7, 8'h00, 6));
        cmd_valid = 1'b0;
        drain();

        // F0 + 20 carries out
        send(4'd0, 9'd10, 9'd11, 9'd12, 1'b1, mk(3, 8'h10, 1'b1, 9'd12, 8'h10, 6));
        cmd_valid = 1'b0;
        drain();

        // nop code 12
`ifdef ALU_SEQ_NOP_SKIP_EN
        send(4'd12, 9'd9, 9'd9, 9'd9, 1'b1, mk(4, 8'h10, 1'b1, 9'd9, 8'hAA, 1));
`else
        send(4'd12, 9'd9, 9'd9, 9'd9, 1'b1, mk(4, 8'h00, 1'b0, 9'd9, 8'h00, 6));
`endif
        cmd_valid = 1'b0;
        drain();

        // back-to-back: xnor F0,3C -> 33 into addr_a; nor 5A,C3 -> 24
        send(4'd7, 9'd20, 9'd21, 9'd20, 1'b1, mk(5, 8'h33, 1'b0, 9'd20, 8'h33, 6));
        cmd_op     = 4'd4;
        cmd_addr_a = 9'd30;
        cmd_addr_b = 9'd31;
        cmd_addr_z = 9'd22;
        exp_q.push_back(mk(6, 8'h24, 1'b0, 9'd22, 8'h24, 6));
        low_cnt = 0;
        @(negedge clk);
        while (!cmd_ready && low_cnt < 20) begin
            low_cnt++;
            @(negedge clk);
        end
        check("b2b_ready_low_cycles", low_cnt, 32'd5);
        check("b2b_accept_in_done", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        drain();

        // reset while in EXEC: abandoned, no write, result cleared
        send(4'd0, 9'd3, 9'd4, 9'd13, 1'b0, dummy);
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        we_seen   = 1'b0;
        done_seen = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_result", {24'd0, result}, 32'd0);
        check("abort_ovf", {31'd0, result_ovf}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            we_seen   = we_seen | mem_WE;
            done_seen = done_seen | done;
            @(negedge clk);
        end
        check("abort_no_write", {31'd0, we_seen}, 32'd0);
        check("abort_no_done", {31'd0, done_seen}, 32'd0);
        check("abort_mem_kept", {24'd0, mem[13]}, 32'h77);
        @(posedge clk);
        #1;

        // recovery: 38 - 13 into 21
        send(4'd1, 9'd5, 9'd4, 9'd21, 1'b1, mk(7, 8'h25, 1'b0, 9'd21, 8'h25, 6));
        cmd_valid = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        #1;

        check("pending_accepts", acc_q.size(), 32'd0);
        check("pending_expects", exp_q.size(), 32'd0);
        check("protocol_violations", proto_err, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
